// File: rtl/uart_wb_bridge_pkg.sv
// uart_wb_bridge_pkg
//   Shared definitions for the UART-to-Wishbone command bridge: the frame
//   state encoding, the command bytes the host sends and the single-byte
//   response codes the bridge returns.
package uart_wb_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,   // waiting for a command byte
      ADDR,   // collecting 4 address bytes, MSB first
      DATA,   // collecting 4 write-data bytes, MSB first
      BUS,    // Wishbone cycle in flight
      RESP    // streaming the response bytes out
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
   localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

endpackage

// File: rtl/uart_wb_bridge_if.sv
// uart_wb_bridge_if
//   Wishbone classic bus between the bridge (master) and the accelerator
//   (slave). Signal names keep the master's _o/_i view so both ends of the
//   link read the same as the bridge's port list.
//     wb_adr_o  32  address            wb_dat_o  32  write data
//     wb_sel_o   4  byte selects       wb_we_o    1  write enable
//     wb_cyc_o   1  cycle valid        wb_stb_o   1  strobe
//     wb_ack_i   1  slave acknowledge  wb_dat_i  32  read data
interface uart_wb_bridge_if;

   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic [31:0] wb_dat_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_ack_i, wb_dat_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_ack_i, wb_dat_i
   );

endinterface

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge
//   Turns a byte stream from a UART receive FIFO into single Wishbone
//   transfers and streams the reply back to the UART transmit FIFO.
//     Frame 'W' a3 a2 a1 a0 d3 d2 d1 d0  -> write, reply 0x06
//     Frame 'R' a3 a2 a1 a0              -> read,  reply 4 data bytes MSB first
//     Any other command byte             -> reply 0x15, no bus cycle
//   Ports:
//     wb_clk_i            clock
//     wb_rst_i            asynchronous active-low reset
//     rx_data/valid/ready command byte stream in (byte taken on valid&ready)
//     tx_data/valid/ready response byte stream out
//     wb                  Wishbone master (uart_wb_bridge_if.master)
//     busy                high whenever a frame is in progress
//   Build option:
//     BRIDGE_TIMEOUT_EN   when defined, a bus cycle without ack for
//                         TIMEOUT_CYCLES clocks is abandoned and answered
//                         with 0x15; otherwise the bridge waits forever.
module uart_wb_bridge
   import uart_wb_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   uart_wb_bridge_if.master         wb,
   output logic                     busy
);

   generate
      if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
         $error("uart_wb_bridge: TIMEOUT_CYCLES must be in 1..65535");
      end
   endgenerate

   state_t      state;
   logic        write_flag;
   logic [1:0]  byte_cnt;    // bytes already taken in ADDR/DATA
   logic [1:0]  resp_left;   // response bytes still to send after the current one
   logic [31:0] rd_data;
   logic [31:0] adr_q;
   logic [31:0] dat_q;
   logic [3:0]  sel_q;
   logic        we_q;
   logic        cyc_q;
   logic        stb_q;
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic        rx_fire;

`ifdef BRIDGE_TIMEOUT_EN
   logic [15:0] bus_timer;
   logic        timeout_hit;
   // Expires on the TIMEOUT_CYCLES-th clock spent in BUS.
   assign timeout_hit = (bus_timer == 16'(TIMEOUT_CYCLES - 1));
`endif

   assign rx_ready = (state == IDLE) || (state == ADDR) || (state == DATA);
   assign rx_fire  = rx_valid && rx_ready;
   assign busy     = (state != IDLE);

   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_sel_o = sel_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_cyc_o = cyc_q;
   assign wb.wb_stb_o = stb_q;
   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;

   // NOTE: all state here updates with non-blocking assignments so every
   // register sees the pre-edge value of every other register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state      <= IDLE;
         write_flag <= 1'b0;
         byte_cnt   <= 2'd0;
         resp_left  <= 2'd0;
         rd_data    <= 32'd0;
         adr_q      <= 32'd0;
         dat_q      <= 32'd0;
         sel_q      <= 4'd0;
         we_q       <= 1'b0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         tx_data_q  <= 8'd0;
         tx_valid_q <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
         bus_timer  <= 16'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (rx_fire) begin
                  byte_cnt <= 2'd0;
                  if (rx_data == CMD_WRITE) begin
                     write_flag <= 1'b1;
                     state      <= ADDR;
                  end else if (rx_data == CMD_READ) begin
                     write_flag <= 1'b0;
                     state      <= ADDR;
                  end else begin
                     tx_data_q  <= RSP_NAK;
                     tx_valid_q <= 1'b1;
                     resp_left  <= 2'd0;
                     state      <= RESP;
                  end
               end
            end

            ADDR: begin
               if (rx_fire) begin
                  adr_q    <= {adr_q[23:0], rx_data};
                  byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 after the 4th byte
                  if (byte_cnt == 2'd3) begin
                     if (write_flag) begin
                        state <= DATA;
                     end else begin
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
                        we_q  <= 1'b0;
                        sel_q <= 4'hF;
`ifdef BRIDGE_TIMEOUT_EN
                        bus_timer <= 16'd0;
`endif
                        state <= BUS;
                     end
                  end
               end
            end

            DATA: begin
               if (rx_fire) begin
                  dat_q    <= {dat_q[23:0], rx_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     cyc_q <= 1'b1;
                     stb_q <= 1'b1;
                     we_q  <= 1'b1;
                     sel_q <= 4'hF;
`ifdef BRIDGE_TIMEOUT_EN
                     bus_timer <= 16'd0;
`endif
                     state <= BUS;
                  end
               end
            end

            BUS: begin
               // Ack is tested first so it wins over a same-clock expiry.
               if (wb.wb_ack_i) begin
                  cyc_q      <= 1'b0;
                  stb_q      <= 1'b0;
                  we_q       <= 1'b0;
                  sel_q      <= 4'd0;
                  rd_data    <= wb.wb_dat_i;
                  tx_valid_q <= 1'b1;
                  if (write_flag) begin
                     tx_data_q <= RSP_ACK;
                     resp_left <= 2'd0;
                  end else begin
                     tx_data_q <= wb.wb_dat_i[31:24];
                     resp_left <= 2'd3;
                  end
                  state <= RESP;
               end
`ifdef BRIDGE_TIMEOUT_EN
               else if (timeout_hit) begin
                  cyc_q      <= 1'b0;
                  stb_q      <= 1'b0;
                  we_q       <= 1'b0;
                  sel_q      <= 4'd0;
                  tx_data_q  <= RSP_NAK;
                  tx_valid_q <= 1'b1;
                  resp_left  <= 2'd0;
                  state      <= RESP;
               end else begin
                  bus_timer <= bus_timer + 16'd1;
               end
`endif
            end

            RESP: begin
               if (tx_ready) begin
                  if (resp_left == 2'd0) begin
                     tx_valid_q <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     // rd_data rotates a byte per send; byte [23:16] is next.
                     tx_data_q <= rd_data[23:16];
                     rd_data   <= {rd_data[23:0], rd_data[31:24]};
                     resp_left <= resp_left - 2'd1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge
//   Directed and randomized frames driven into uart_wb_bridge, with a
//   Wishbone slave responder, a transmit-side sink and a frame-level
//   reference model predicting the reply bytes and bus transfer.
//   Timeout scenarios run only when BRIDGE_TIMEOUT_EN is defined.
module tb_uart_wb_bridge;

   localparam int TO = 8;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
      logic [3:0]  sel;
   } txn_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic       busy;

   uart_wb_bridge_if bus ();

   uart_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .wb       (bus),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- Wishbone slave ----------------
   int          slave_wait  = 0;
   logic [31:0] slave_rdata = 32'd0;
   bit          slave_mute  = 1'b0;
   bit          stray_ack   = 1'b0;
   int          wait_cnt    = 0;
   txn_t        txn_q[$];

   initial begin
      bus.wb_ack_i = 1'b0;
      bus.wb_dat_i = 32'd0;
      forever begin
         @(negedge clk);
         if (!bus.wb_cyc_o) wait_cnt = 0;
         if (bus.wb_ack_i) begin
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = 32'd0;
            check_eq("cyc_stb_low_after_ack", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
         end else if (stray_ack) begin
            stray_ack    = 1'b0;
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = 32'hBAD0BAD0;
         end else if (bus.wb_cyc_o && bus.wb_stb_o && !slave_mute) begin
            if (wait_cnt == slave_wait) begin
               bus.wb_ack_i = 1'b1;
               bus.wb_dat_i = slave_rdata;
               txn_q.push_back('{adr: bus.wb_adr_o, dat: bus.wb_dat_o,
                                 we: bus.wb_we_o, sel: bus.wb_sel_o});
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // ---------------- cycle-length monitor ----------------
   int cyc_rises = 0;
   int cur_len   = 0;
   int last_len  = 0;
   logic prev_cyc = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (bus.wb_cyc_o) begin
            if (!prev_cyc) cyc_rises++;
            cur_len++;
         end else if (prev_cyc) begin
            last_len = cur_len;
            cur_len  = 0;
         end
         prev_cyc = bus.wb_cyc_o;
      end
   end

   // ---------------- transmit sink ----------------
   bit         hold_low     = 1'b0;
   bit         ready_random = 1'b0;
   bit         pend         = 1'b0;
   logic [7:0] pend_data    = 8'd0;
   byte_q_t    tx_q;

   initial begin
      forever begin
         @(negedge clk);
         tx_ready = hold_low ? 1'b0 : (ready_random ? 1'($urandom_range(0, 1)) : 1'b1);
         if (pend) begin
            check_eq("tx_valid_held", 32'(tx_valid), 32'd1);
            check_eq("tx_data_stable", 32'(tx_data), 32'(pend_data));
         end
         if (tx_valid && tx_ready) begin
            tx_q.push_back(tx_data);
            pend = 1'b0;
         end else if (tx_valid) begin
            pend      = 1'b1;
            pend_data = tx_data;
         end else begin
            pend = 1'b0;
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic byte_q_t model_resp(input logic [7:0] cmd, input logic [31:0] rdata,
                                          input bit timed_out);
      byte_q_t r;
      if (cmd == 8'h57) begin
         if (timed_out) r.push_back(8'h15); else r.push_back(8'h06);
      end else if (cmd == 8'h52) begin
         if (timed_out) r.push_back(8'h15);
         else for (int i = 3; i >= 0; i--) r.push_back(8'((rdata >> (8 * i)) & 32'hFF));
      end else begin
         r.push_back(8'h15);
      end
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) check_eq("rx_ready_wait_timeout", 32'(rx_ready), 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy) check_eq({tag, "_idle_timeout"}, 32'(busy), 32'd0);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] adr,
                            input logic [31:0] dat, input int wait_states, input bit mute,
                            input bit timed_out, input int stall);
      byte_q_t exp_tx;
      int      rises0;
      bit      valid_cmd;
      int      n;
      valid_cmd = (cmd == 8'h57) || (cmd == 8'h52);
      tx_q.delete();
      txn_q.delete();
      rises0      = cyc_rises;
      slave_wait  = wait_states;
      slave_rdata = dat;
      slave_mute  = mute;
      exp_tx      = model_resp(cmd, dat, timed_out);
      if (stall > 0) hold_low = 1'b1;
      send_byte(cmd);
      if (valid_cmd) begin
         for (int i = 3; i >= 0; i--) send_byte(adr[8 * i +: 8]);
         if (cmd == 8'h57) for (int i = 3; i >= 0; i--) send_byte(dat[8 * i +: 8]);
      end
      if (stall > 0) begin
         n = 0;
         while (!tx_valid && n < 500) begin
            @(negedge clk);
            n++;
         end
         repeat (stall) @(negedge clk);
         check_eq({tag, "_stall_no_tx"}, 32'(tx_q.size()), 32'd0);
         check_eq({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
         check_eq({tag, "_stall_data"}, 32'(tx_data), 32'(exp_tx[0]));
         hold_low = 1'b0;
      end
      wait_idle(tag);
      check_eq({tag, "_tx_count"}, 32'(tx_q.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size(); i++)
         if (i < tx_q.size()) check_eq($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_tx[i]));
      check_eq({tag, "_bus_cycles"}, 32'(cyc_rises - rises0), valid_cmd ? 32'd1 : 32'd0);
      if (valid_cmd && !timed_out) begin
         check_eq({tag, "_acked_txns"}, 32'(txn_q.size()), 32'd1);
         if (txn_q.size() > 0) begin
            check_eq({tag, "_adr"}, txn_q[0].adr, adr);
            check_eq({tag, "_we"}, 32'(txn_q[0].we), (cmd == 8'h57) ? 32'd1 : 32'd0);
            check_eq({tag, "_sel"}, 32'(txn_q[0].sel), 32'hF);
            if (cmd == 8'h57) check_eq({tag, "_dat"}, txn_q[0].dat, dat);
         end
      end
      if (timed_out) begin
         check_eq({tag, "_acked_txns"}, 32'(txn_q.size()), 32'd0);
         check_eq({tag, "_cyc_len"}, 32'(last_len), 32'(TO));
      end
      slave_mute = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_adr"}, bus.wb_adr_o, 32'd0);
      check_eq({tag, "_dat"}, bus.wb_dat_o, 32'd0);
      check_eq({tag, "_ctl"}, {25'd0, bus.wb_sel_o, bus.wb_we_o, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
      check_eq({tag, "_tx"}, {23'd0, tx_valid, tx_data}, 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0]  cmd;
      logic [31:0] a, d;
      int          sel;

      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Write frame.
      run_frame("write", 8'h57, 32'h30000004, 32'hDEADBEEF, 0, 1'b0, 1'b0, 0);

      // Read with three wait states.
      run_frame("read_ws3", 8'h52, 32'h30800000, 32'h12345678, 3, 1'b0, 1'b0, 0);

      // Unknown command, then a normal read.
      run_frame("bad_cmd", 8'h41, 32'd0, 32'd0, 0, 1'b0, 1'b0, 0);
      run_frame("after_bad", 8'h52, 32'h00000010, 32'hCAFEF00D, 1, 1'b0, 1'b0, 0);

      // Transmit back-pressure for 20 clocks during a read reply.
      run_frame("stall", 8'h52, 32'h0000ABCD, 32'h12345678, 2, 1'b0, 1'b0, 20);

      // Ack while idle must be ignored.
      tx_q.delete();
      stray_ack = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("stray_ack_busy", 32'(busy), 32'd0);
      check_eq("stray_ack_tx", 32'(tx_q.size()), 32'd0);

`ifdef BRIDGE_TIMEOUT_EN
      run_frame("timeout", 8'h52, 32'h40000000, 32'h0, 0, 1'b1, 1'b1, 0);
      run_frame("ack_at_limit", 8'h52, 32'h40000004, 32'hA5C3E1F0, TO - 1, 1'b0, 1'b0, 0);
`endif

      // Reset after two address bytes, then a full write.
      tx_q.delete();
      send_byte(8'h57);
      send_byte(8'h30);
      send_byte(8'h00);
      rst_n = 1'b0;
      #1;
      check_reset_state("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("mid_reset_no_nak", 32'(tx_q.size()), 32'd0);
      run_frame("post_reset_write", 8'h57, 32'h30000008, 32'h01020304, 0, 1'b0, 1'b0, 0);

      // Randomized frames with random back-pressure and wait states.
      ready_random = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sel = $urandom_range(0, 2);
         a   = $urandom;
         d   = $urandom;
         if (sel == 0) cmd = 8'h57;
         else if (sel == 1) cmd = 8'h52;
         else begin
            cmd = 8'($urandom);
            if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'h00;
         end
         run_frame($sformatf("rand%0d", k), cmd, a, d, $urandom_range(0, 4), 1'b0, 1'b0, 0);
      end
      ready_random = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_wb_bridge.md
UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the bus-wait limit in clocks (range 1..65535).
REQ-002 SHALL have ports in this order: wb_clk_i in 1 clock; wb_rst_i in 1 reset, asynchronous, active-low.
REQ-003 SHALL have rx_data in 8 / rx_valid in 1 / rx_ready out 1 as the command byte stream from the UART receive FIFO.
REQ-004 SHALL have tx_data out 8 / tx_valid out 1 / tx_ready in 1 as the response byte stream to the UART transmit FIFO.
REQ-005 SHALL have the Wishbone master ports wb_adr_o out 32, wb_dat_o out 32, wb_sel_o out 4, wb_we_o out 1, wb_cyc_o out 1, wb_stb_o out 1, wb_ack_i in 1, wb_dat_i in 32, driving the accelerator's slave bus.
REQ-006 SHALL have busy out 1, high whenever the state is not IDLE.

Function
REQ-007 SHALL accept a byte when rx_valid and rx_ready are both high on a rising edge.
REQ-008 SHALL implement states IDLE, ADDR, DATA, BUS and RESP.
REQ-009 SHALL drive rx_ready high in IDLE, ADDR and DATA, and low in BUS and RESP.
REQ-010 SHALL, in IDLE, on command 0x57 ('W') set a write flag and go to ADDR; on 0x52 ('R') clear the flag and go to ADDR; on any other byte queue NAK 0x15 and go to RESP.
REQ-011 SHALL, in ADDR, shift in 4 bytes MSB-first into wb_adr_o using a 2-bit counter; after the 4th byte it SHALL go to DATA if writing, else to BUS.
REQ-012 SHALL, in DATA, shift in 4 bytes MSB-first into wb_dat_o, then go to BUS.
REQ-013 SHALL assert wb_cyc_o, wb_stb_o and wb_we_o (= write flag) on the clock after the final byte is accepted; wb_sel_o SHALL be 4'hF during the cycle.
REQ-014 SHALL, on the clock where wb_ack_i is sampled high in BUS, drop cyc/stb on that edge and capture wb_dat_i into a read register; the queued response SHALL be ACK 0x06 for a write, or the 4 read bytes MSB-first for a read.
REQ-015 SHALL, in RESP, present each response byte with tx_valid high and tx_data held stable until tx_ready is high; after the last byte it SHALL return to IDLE with tx_valid low on the next clock.
REQ-016 SHALL ignore wb_ack_i outside BUS.
REQ-017 SHALL treat the stream as continuous: a new command may be accepted the cycle after RESP exits; no framing timeout on rx exists.

Reset
REQ-018 SHALL, on wb_rst_i low at any time, including mid-frame or mid-bus-cycle, force IDLE and zero wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, tx_data, tx_valid, busy, the counters and the read register; rx_ready SHALL read 1 after reset.
REQ-019 SHALL drop an aborted frame silently, with no NAK sent after reset.

Configuration
REQ-020 SHALL, with BRIDGE_TIMEOUT_EN defined, count clocks in BUS; when TIMEOUT_CYCLES clocks pass without ack it SHALL drop cyc/stb, queue NAK 0x15 and go to RESP.
REQ-021 SHALL, if ack and expiry occur on the same clock, give ack precedence.
REQ-022 SHALL, without BRIDGE_TIMEOUT_EN, wait in BUS indefinitely, with no counter logic synthesized.

Structure
REQ-023 SHALL take the state enum, the command constants CMD_WRITE=0x57 and CMD_READ=0x52, and the response constants RSP_ACK=0x06 and RSP_NAK=0x15 from shared package uart_wb_bridge_pkg.
REQ-024 SHALL be one flat module; no sub-module is warranted.

Verification
REQ-025 SHALL cover: bytes 57 30 00 00 04 DE AD BE EF -> one cycle with adr 0x30000004, dat 0xDEADBEEF, we=1, sel=F; tx byte 0x06.
REQ-026 SHALL cover: bytes 52 30 80 00 00, slave returns 0x12345678 after 3 wait states -> tx bytes 12 34 56 78 in order; cyc low one clock after ack.
REQ-027 SHALL cover: byte 0x41 -> tx byte 0x15, no Wishbone cycle, next valid command processed normally.
REQ-028 SHALL cover: tx_ready held low 20 clocks during a read response -> tx_data stable, no byte lost or repeated.
REQ-029 SHALL cover: with BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, a read with no ack -> cyc drops after 8 clocks, tx 0x15; a second run with ack on clock 8 -> data bytes returned, not NAK.
REQ-030 SHALL cover: reset asserted after 2 address bytes -> all outputs 0 and busy low; a following full write frame completes correctly.
